hbm_rdata_demux: RTL and testbench

// - Consumes the AXI R channel of one HBM pseudo-channel.
// - This is the read-data side paired with the engine's AR address generator.
// - Splits returned beats by RID into the A (sample) stream and B (label) stream, each buffered in a FWFT FIFO.
// - Checks burst framing and response codes; counts beats; flags completion to the SGD engine.

---
 rtl/hbm_rdata_demux_pkg.sv | 17 +
 rtl/hbm_rdata_demux_if.sv | 34 +++
 rtl/hbm_rdata_demux_fifo.sv | 49 ++++
 rtl/hbm_rdata_demux.sv | 121 ++++++++++++
 tb/tb_hbm_rdata_demux.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hbm_rdata_demux_pkg.sv
// Shared constants for the HBM read-data demux: RID tags, error bit positions,
// stream indices.
package hbm_rdata_demux_pkg;
  localparam logic [5:0] MEM_RD_A_TAG = 6'h01;
  localparam logic [5:0] MEM_RD_B_TAG = 6'h02;

  localparam int ERR_BAD_LAST = 0;
  localparam int ERR_BAD_RESP = 1;
  localparam int ERR_BAD_ID   = 2;
  localparam int ERR_W        = 3;

  localparam int NUM_STRM = 2;
  localparam int STRM_A   = 0;
  localparam int STRM_B   = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/hbm_rdata_demux_if.sv
// AXI R channel plus the two demuxed output streams of one pseudo-channel.
interface hbm_rdata_demux_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6
);
  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;
  logic [DATA_WIDTH-1:0] m_axi_RDATA;
  logic [ID_WIDTH-1:0]   m_axi_RID;
  logic [1:0]            m_axi_RRESP;
  logic                  m_axi_RLAST;
  logic [DATA_WIDTH-1:0] a_tdata;
  logic                  a_tvalid;
  logic                  a_tready;
  logic [DATA_WIDTH-1:0] b_tdata;
  logic                  b_tvalid;
  logic                  b_tready;

  // environment side: drives R channel, consumes streams
  modport master (
    output m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RRESP, m_axi_RLAST,
    input  m_axi_RREADY,
    input  a_tdata, a_tvalid, b_tdata, b_tvalid,
    output a_tready, b_tready
  );

  // demux side
  modport slave (
    input  m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RRESP, m_axi_RLAST,
    output m_axi_RREADY,
    output a_tdata, a_tvalid, b_tdata, b_tvalid,
    input  a_tready, b_tready
  );
endinterface

// File: rtl/hbm_rdata_demux_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible the cycle after push.
module hbm_rdata_fifo #(
  parameter  int DATA_WIDTH = 256,
  parameter  int FIFO_DEPTH = 64,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [AW:0]           count_o,
  output logic                  empty_o,
  output logic                  full_o
);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q;
  logic                  wr_en, rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[AW];
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/hbm_rdata_demux.sv
// HBM R-channel demux: RID split into A/B FWFT FIFOs, burst/response checking,
// per-run beat counters and completion flag.
module hbm_rdata_demux
  import hbm_rdata_demux_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  parameter  int ID_WIDTH   = 6,
  parameter  int BURST_LEN  = 4,
  parameter  int FIFO_DEPTH = 64,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1,
  localparam int BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic             hbm_clk,
  input  logic             hbm_rst,
  input  logic             start,
  input  logic [31:0]      expected_beats,
  hbm_rdata_demux_if.slave axi,
  output logic             rd_data_done,
  output logic [ERR_W-1:0] err_flags,
  output logic [31:0]      a_beat_cnt,
  output logic [31:0]      b_beat_cnt
);
  logic [NUM_STRM-1:0][DATA_WIDTH-1:0] dout;
  logic [NUM_STRM-1:0][CW-1:0]         cnt;
  logic [NUM_STRM-1:0]                 push, pop, empty, full, tready;

  logic [1:0]       start_q;
  logic             start_edge, accept, hit_a, hit_b, last_exp;
  logic [ERR_W-1:0] err_now;
  logic [BW-1:0]    beat_d, beat_q;
  logic [31:0]      a_cnt_d, a_cnt_q, b_cnt_d, b_cnt_q, exp_d, exp_q;
  logic [ERR_W-1:0] err_d, err_q;
  logic             done_d, done_q;

  assign start_edge       = start_q[0] & ~start_q[1];
  assign axi.m_axi_RREADY = ~hbm_rst & ~full[STRM_A] & ~full[STRM_B];
  assign accept           = axi.m_axi_RVALID & axi.m_axi_RREADY;
  assign hit_a            = (axi.m_axi_RID == ID_WIDTH'(MEM_RD_A_TAG));
  assign hit_b            = (axi.m_axi_RID == ID_WIDTH'(MEM_RD_B_TAG));
  assign push[STRM_A]     = accept & hit_a;
  assign push[STRM_B]     = accept & hit_b;
  assign last_exp         = (beat_q == BW'(BURST_LEN - 1));

  assign tready[STRM_A] = axi.a_tready;
  assign tready[STRM_B] = axi.b_tready;
  assign pop            = ~empty & tready;
  assign axi.a_tdata    = dout[STRM_A];
  assign axi.a_tvalid   = ~empty[STRM_A];
  assign axi.b_tdata    = dout[STRM_B];
  assign axi.b_tvalid   = ~empty[STRM_B];

  for (genvar s = 0; s < NUM_STRM; s++) begin : g_fifo
    hbm_rdata_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i  (hbm_clk),
      .rst_i  (hbm_rst),
      .push_i (push[s]),
      .din_i  (axi.m_axi_RDATA),
      .pop_i  (pop[s]),
      .dout_o (dout[s]),
      .count_o(cnt[s]),
      .empty_o(empty[s]),
      .full_o (full[s])
    );
  end

  always_comb begin
    err_now               = '0;
    err_now[ERR_BAD_ID]   = accept & ~hit_a & ~hit_b;
    err_now[ERR_BAD_RESP] = accept & (axi.m_axi_RRESP != RESP_OKAY);
    err_now[ERR_BAD_LAST] = accept & (axi.m_axi_RLAST != last_exp);
  end

  always_comb begin
    beat_d  = beat_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    done_d  = done_q;
    // RLAST always resyncs the burst position, even when it came early
    if (accept) beat_d = (axi.m_axi_RLAST | last_exp) ? '0 : beat_q + 1'b1;
    if (start_edge) begin
      a_cnt_d = {31'b0, push[STRM_A]};
      b_cnt_d = {31'b0, push[STRM_B]};
      exp_d   = expected_beats;
      err_d   = err_now;
      done_d  = 1'b0;
    end else begin
      a_cnt_d = a_cnt_q + {31'b0, push[STRM_A]};
      b_cnt_d = b_cnt_q + {31'b0, push[STRM_B]};
      err_d   = err_q | err_now;
      if ((a_cnt_q + b_cnt_q == exp_q) && (cnt[STRM_A] == '0) && (cnt[STRM_B] == '0))
        done_d = 1'b1;
    end
  end

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      start_q <= '0;
      beat_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      start_q <= {start_q[0], start};
      beat_q  <= beat_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rd_data_done = done_q;
  assign err_flags    = err_q;
  assign a_beat_cnt   = a_cnt_q;
  assign b_beat_cnt   = b_cnt_q;
endmodule

// File: tb/tb_hbm_rdata_demux.sv
// Directed bench for hbm_rdata_demux: reset, interleave, backpressure, framing
// errors, restart, zero-length run, reset mid-burst.
module tb_hbm_rdata_demux;
  import hbm_rdata_demux_pkg::*;

  localparam int DW = 256;
  localparam int IW = 6;

  logic        hbm_clk = 1'b0;
  logic        hbm_rst;
  logic        start;
  logic [31:0] expected_beats;
  logic        rd_data_done;
  logic [2:0]  err_flags;
  logic [31:0] a_beat_cnt, b_beat_cnt;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  hbm_rdata_demux_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) rif ();

  hbm_rdata_demux #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN(4), .FIFO_DEPTH(64)) dut (
    .hbm_clk       (hbm_clk),
    .hbm_rst       (hbm_rst),
    .start         (start),
    .expected_beats(expected_beats),
    .axi           (rif.slave),
    .rd_data_done  (rd_data_done),
    .err_flags     (err_flags),
    .a_beat_cnt    (a_beat_cnt),
    .b_beat_cnt    (b_beat_cnt)
  );

  always #5 hbm_clk = ~hbm_clk;

  always @(posedge hbm_clk) begin
    if (rif.a_tvalid && rif.a_tready) qa.push_back(rif.a_tdata);
    if (rif.b_tvalid && rif.b_tready) qb.push_back(rif.b_tdata);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hbm_clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] id, input logic [DW-1:0] d,
                      input logic last, input logic [1:0] resp);
    int n = 0;
    rif.m_axi_RVALID = 1'b1;
    rif.m_axi_RID    = id;
    rif.m_axi_RDATA  = d;
    rif.m_axi_RLAST  = last;
    rif.m_axi_RRESP  = resp;
    while (!rif.m_axi_RREADY && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("rready_timeout", rif.m_axi_RREADY, 1);
    tick();
    rif.m_axi_RVALID = 1'b0;
  endtask

  task automatic run_start(input logic [31:0] exp);
    start = 1'b0;
    tick();
    tick();
    expected_beats = exp;
    start = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!rd_data_done && n < 300) begin
      tick();
      n++;
    end
    chk(tag, rd_data_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    hbm_rst = 1'b1;
    start = 1'b0;
    expected_beats = '0;
    rif.m_axi_RVALID = 1'b1;
    rif.m_axi_RID    = MEM_RD_A_TAG;
    rif.m_axi_RDATA  = '0;
    rif.m_axi_RLAST  = 1'b0;
    rif.m_axi_RRESP  = 2'b00;
    rif.a_tready = 1'b1;
    rif.b_tready = 1'b1;

    // 1. reset with RVALID held high
    repeat (3) tick();
    chk("rst_rready", rif.m_axi_RREADY, 0);
    chk("rst_atvalid", rif.a_tvalid, 0);
    chk("rst_btvalid", rif.b_tvalid, 0);
    chk("rst_acnt", a_beat_cnt, 0);
    chk("rst_bcnt", b_beat_cnt, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_done", rd_data_done, 0);
    rif.m_axi_RVALID = 1'b0;
    hbm_rst = 1'b0;
    tick();

    // 2. interleave A/B/A bursts
    run_start(12);
    for (int i = 0; i < 4; i++) send(MEM_RD_A_TAG, DW'('h100 + i), i == 3, 2'b00);
    for (int i = 0; i < 4; i++) send(MEM_RD_B_TAG, DW'('h200 + i), i == 3, 2'b00);
    for (int i = 0; i < 4; i++) send(MEM_RD_A_TAG, DW'('h104 + i), i == 3, 2'b00);
    wait_done("il_done");
    chk("il_acnt", a_beat_cnt, 8);
    chk("il_bcnt", b_beat_cnt, 4);
    chk("il_err", err_flags, 0);
    chk("il_qa_size", qa.size(), 8);
    chk("il_qb_size", qb.size(), 4);
    bad = 0;
    for (int i = 0; i < 8 && i < qa.size(); i++) if (qa[i] !== DW'('h100 + i)) bad++;
    for (int i = 0; i < 4 && i < qb.size(); i++) if (qb[i] !== DW'('h200 + i)) bad++;
    chk("il_order", bad, 0);

    // 3. backpressure: fill A to depth, then drain
    qa.delete();
    qb.delete();
    rif.a_tready = 1'b0;
    run_start(64);
    for (int i = 0; i < 64; i++) send(MEM_RD_A_TAG, DW'('h3000 + i), (i % 4) == 3, 2'b00);
    chk("bp_rready_full", rif.m_axi_RREADY, 0);
    rif.m_axi_RVALID = 1'b1;
    rif.m_axi_RID    = MEM_RD_A_TAG;
    rif.m_axi_RDATA  = DW'('hDEAD);
    rif.m_axi_RLAST  = 1'b0;
    repeat (3) tick();
    chk("bp_no_overflow", a_beat_cnt, 64);
    rif.m_axi_RVALID = 1'b0;
    rif.a_tready = 1'b1;
    wait_done("bp_done");
    chk("bp_qa_size", qa.size(), 64);
    bad = 0;
    for (int i = 0; i < 64 && i < qa.size(); i++) if (qa[i] !== DW'('h3000 + i)) bad++;
    chk("bp_data", bad, 0);

    // 4. framing, bad id, bad response
    qa.delete();
    qb.delete();
    run_start(100);
    send(MEM_RD_A_TAG, DW'('h400), 1'b0, 2'b00);
    send(MEM_RD_A_TAG, DW'('h401), 1'b1, 2'b00);
    chk("fr_bad_last", err_flags, 3'b001);
    send(6'h3F, DW'('h4FF), 1'b0, 2'b00);
    chk("fr_bad_id", err_flags, 3'b101);
    send(MEM_RD_A_TAG, DW'('h4444), 1'b0, 2'b10);
    chk("fr_bad_resp", err_flags, 3'b111);
    send(MEM_RD_A_TAG, DW'('h403), 1'b1, 2'b00);
    repeat (3) tick();
    chk("fr_qa_size", qa.size(), 4);
    chk("fr_qb_size", qb.size(), 0);
    if (qa.size() >= 3) chk("fr_resp_data", qa[2], DW'('h4444));
    chk("fr_acnt", a_beat_cnt, 4);
    chk("fr_bcnt", b_beat_cnt, 0);

    // 5. restart mid-run
    run_start(8);
    for (int i = 0; i < 5; i++) send(MEM_RD_A_TAG, DW'('h500 + i), i == 3, 2'b00);
    chk("rs_acnt_pre", a_beat_cnt, 5);
    run_start(4);
    chk("rs_acnt_clr", a_beat_cnt, 0);
    chk("rs_err_clr", err_flags, 0);
    for (int i = 0; i < 3; i++) send(MEM_RD_A_TAG, DW'('h510 + i), i == 2, 2'b00);
    repeat (3) tick();
    chk("rs_not_done", rd_data_done, 0);
    send(MEM_RD_A_TAG, DW'('h513), 1'b0, 2'b00);
    wait_done("rs_done");
    chk("rs_acnt", a_beat_cnt, 4);
    chk("rs_err", err_flags, 0);

    // zero-length run: done exactly two cycles after the start edge
    start = 1'b0;
    repeat (3) tick();
    expected_beats = 0;
    start = 1'b1;
    tick();
    tick();
    chk("z_done_early", rd_data_done, 0);
    tick();
    chk("z_done", rd_data_done, 1);

    // 6. reset mid-burst, then a clean burst
    run_start(4);
    rif.a_tready = 1'b0;
    send(MEM_RD_A_TAG, DW'('h600), 1'b0, 2'b00);
    send(MEM_RD_A_TAG, DW'('h601), 1'b0, 2'b00);
    chk("mr_pre_tvalid", rif.a_tvalid, 1);
    start = 1'b0;
    hbm_rst = 1'b1;
    tick();
    chk("mr_tvalid", rif.a_tvalid, 0);
    chk("mr_acnt", a_beat_cnt, 0);
    chk("mr_rready", rif.m_axi_RREADY, 0);
    hbm_rst = 1'b0;
    rif.a_tready = 1'b1;
    qa.delete();
    run_start(4);
    for (int i = 0; i < 4; i++) send(MEM_RD_A_TAG, DW'('h610 + i), i == 3, 2'b00);
    wait_done("mr_done");
    chk("mr_err", err_flags, 0);
    chk("mr_acnt_after", a_beat_cnt, 4);
    chk("mr_qa_size", qa.size(), 4);
    if (qa.size() == 4) chk("mr_qa_last", qa[3], DW'('h613));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
